mm_core_datapath: RTL and testbench

- Execution-side counterpart of the microprogrammed control unit: consumes the control word each cycle and returns `ir` and the `z` flag.
- Holds the processor register set, the accumulator ALU and the data-memory port of one matrix-multiplication core.
- One instance per core.
- Data memory is synchronous with fixed 1-cycle read latency.

---
 rtl/mm_core_datapath.sv | 181 ++++++++++++++++++
 tb/tb_mm_core_datapath.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_core_datapath.sv
// Execution datapath of one matrix-multiplication core: register set, accumulator ALU
// and a synchronous data-memory port, all steered by the control word applied each cycle.
module mm_core_datapath #(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int IRW = 8,
  parameter int CW  = 24
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  ctrl,
  input  logic [DW-1:0]  mem_rdata,
  output logic [IRW-1:0] ir,
  output logic           z,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           busy_rd
);

  // Handshake: ctrl is consumed every cycle with no backpressure. A read issued in
  // cycle N (mem_rd high) must have mem_rdata valid in cycle N+1, which is exactly
  // the cycle busy_rd is high; DR captures it at the end of that cycle.

  typedef enum logic [3:0] {
    BUS_ZERO = 4'd0,
    BUS_AR   = 4'd1,
    BUS_DR   = 4'd2,
    BUS_AC   = 4'd3,
    BUS_R1   = 4'd4,
    BUS_R2   = 4'd5,
    BUS_R3   = 4'd6,
    BUS_RC   = 4'd7,
    BUS_CC   = 4'd8,
    BUS_TR   = 4'd9,
    BUS_IR   = 4'd10
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_CLR  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_NOP7 = 3'd7
  } alu_op_e;

  // Architectural registers
  logic [AW-1:0] ar;
  logic [DW-1:0] dr;
  logic [DW-1:0] ac;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;
  logic [DW-1:0] r3;
  logic [DW-1:0] rc;
  logic [DW-1:0] cc;
  logic [DW-1:0] tr;

  // Control word decode
  bus_sel_e bus_sel;
  alu_op_e  alu_op;
  logic ld_ar, ld_dr, ld_ac, ld_r1, ld_r2, ld_r3, ld_rc, ld_cc, ld_tr, ld_ir;
  logic inc_ar, inc_rc, inc_cc, clr_rc, clr_cc;
  logic rd_req, wr_req;

  assign bus_sel = bus_sel_e'(ctrl[3:0]);
  assign ld_ar   = ctrl[4];
  assign ld_dr   = ctrl[5];
  assign ld_ac   = ctrl[6];
  assign ld_r1   = ctrl[7];
  assign ld_r2   = ctrl[8];
  assign ld_r3   = ctrl[9];
  assign ld_rc   = ctrl[10];
  assign ld_cc   = ctrl[11];
  assign ld_tr   = ctrl[12];
  assign ld_ir   = ctrl[13];
  assign alu_op  = alu_op_e'(ctrl[16:14]);
  assign inc_ar  = ctrl[17];
  assign inc_rc  = ctrl[18];
  assign inc_cc  = ctrl[19];
  assign clr_rc  = ctrl[20];
  assign clr_cc  = ctrl[21];
  assign rd_req  = ctrl[22];
  assign wr_req  = ctrl[23];

  // A write wins over a simultaneous read; the read is never issued.
  assign mem_rd    = rd_req & ~wr_req;
  assign mem_wr    = wr_req;
  assign mem_addr  = ar;
  assign mem_wdata = dr;

  logic [DW-1:0] bus;

  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_AR:  bus = DW'(ar);
      BUS_DR:  bus = dr;
      BUS_AC:  bus = ac;
      BUS_R1:  bus = r1;
      BUS_R2:  bus = r2;
      BUS_R3:  bus = r3;
      BUS_RC:  bus = rc;
      BUS_CC:  bus = cc;
      BUS_TR:  bus = tr;
      BUS_IR:  bus = DW'(ir);
      default: bus = '0;
    endcase
  end

  logic          alu_en;
  logic [DW-1:0] alu_res;

  always_comb begin
    alu_en  = 1'b1;
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = ac + bus;
      ALU_SUB:  alu_res = ac - bus;
      ALU_MUL:  alu_res = ac * bus;
      ALU_INC:  alu_res = ac + DW'(1);
      ALU_CLR:  alu_res = '0;
      ALU_PASS: alu_res = bus;
      default: begin
        alu_en  = 1'b0;
        alu_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar      <= '0;
      dr      <= '0;
      ac      <= '0;
      r1      <= '0;
      r2      <= '0;
      r3      <= '0;
      rc      <= '0;
      cc      <= '0;
      tr      <= '0;
      ir      <= '0;
      z       <= 1'b0;
      busy_rd <= 1'b0;
    end else begin
      busy_rd <= mem_rd;

      if (ld_ar)       ar <= bus[AW-1:0];
      else if (inc_ar) ar <= ar + AW'(1);

      // Returning read data owns DR in its capture cycle.
      if (busy_rd)     dr <= mem_rdata;
      else if (ld_dr)  dr <= bus;

      if (alu_en) begin
        ac <= alu_res;
        z  <= (alu_res == '0);
      end else if (ld_ac) begin
        ac <= bus;
      end

      if (ld_r1) r1 <= bus;
      if (ld_r2) r2 <= bus;
      if (ld_r3) r3 <= bus;
      if (ld_tr) tr <= bus;
      if (ld_ir) ir <= bus[IRW-1:0];

      if (clr_rc)      rc <= '0;
      else if (ld_rc)  rc <= bus;
      else if (inc_rc) rc <= rc + DW'(1);

      if (clr_cc)      cc <= '0;
      else if (ld_cc)  cc <= bus;
      else if (inc_cc) cc <= cc + DW'(1);
    end
  end

endmodule

// File: tb/tb_mm_core_datapath.sv
// Directed bench for mm_core_datapath: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares those due in the current cycle.
module tb_mm_core_datapath;

  localparam int W = 16;

  localparam logic [23:0] B_ZERO = 24'd0;
  localparam logic [23:0] B_AR   = 24'd1;
  localparam logic [23:0] B_DR   = 24'd2;
  localparam logic [23:0] B_AC   = 24'd3;
  localparam logic [23:0] B_R1   = 24'd4;
  localparam logic [23:0] B_R2   = 24'd5;
  localparam logic [23:0] B_R3   = 24'd6;
  localparam logic [23:0] B_RC   = 24'd7;
  localparam logic [23:0] B_CC   = 24'd8;
  localparam logic [23:0] B_TR   = 24'd9;
  localparam logic [23:0] B_IR   = 24'd10;
  localparam logic [23:0] B_11   = 24'd11;

  localparam logic [23:0] LD_AR = 24'h1 << 4;
  localparam logic [23:0] LD_DR = 24'h1 << 5;
  localparam logic [23:0] LD_AC = 24'h1 << 6;
  localparam logic [23:0] LD_R1 = 24'h1 << 7;
  localparam logic [23:0] LD_R2 = 24'h1 << 8;
  localparam logic [23:0] LD_R3 = 24'h1 << 9;
  localparam logic [23:0] LD_RC = 24'h1 << 10;
  localparam logic [23:0] LD_CC = 24'h1 << 11;
  localparam logic [23:0] LD_TR = 24'h1 << 12;
  localparam logic [23:0] LD_IR = 24'h1 << 13;
  localparam logic [23:0] OP_ADD  = 24'h1 << 14;
  localparam logic [23:0] OP_SUB  = 24'h2 << 14;
  localparam logic [23:0] OP_MUL  = 24'h3 << 14;
  localparam logic [23:0] OP_INC  = 24'h4 << 14;
  localparam logic [23:0] OP_CLR  = 24'h5 << 14;
  localparam logic [23:0] OP_PASS = 24'h6 << 14;
  localparam logic [23:0] INC_AR = 24'h1 << 17;
  localparam logic [23:0] INC_RC = 24'h1 << 18;
  localparam logic [23:0] INC_CC = 24'h1 << 19;
  localparam logic [23:0] CLR_RC = 24'h1 << 20;
  localparam logic [23:0] CLR_CC = 24'h1 << 21;
  localparam logic [23:0] RD     = 24'h1 << 22;
  localparam logic [23:0] WR     = 24'h1 << 23;

  localparam int S_IR = 0, S_Z = 1, S_ADDR = 2, S_WDATA = 3, S_RD = 4, S_WR = 5, S_BUSY = 6;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] ctrl = '0;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  ir;
  logic        z;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        busy_rd;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mm_core_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .ctrl      (ctrl),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .z         (z),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .busy_rd   (busy_rd)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           sel_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;
  logic [W-1:0] mon_act;

  function automatic logic [W-1:0] actual(input int s);
    case (s)
      S_IR:    return {8'h00, ir};
      S_Z:     return {15'd0, z};
      S_ADDR:  return mem_addr;
      S_WDATA: return mem_wdata;
      S_RD:    return {15'd0, mem_rd};
      S_WR:    return {15'd0, mem_wr};
      default: return {15'd0, busy_rd};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (cyc_q[i] <= cyc) begin
        tests_run++;
        if (cyc_q[i] < cyc) begin
          tests_failed++;
          $display("FAIL %s: check for cycle %0d never sampled (now %0d)", name_q[i], cyc_q[i], cyc);
        end else begin
          mon_act = actual(sel_q[i]);
          if (mon_act !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", name_q[i], mon_act, exp_q[i], cyc);
          end
        end
        exp_q.delete(i);
        cyc_q.delete(i);
        sel_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  // driver tasks
  task automatic push_exp(input int c, input int s, input logic [W-1:0] v, input string nm);
    exp_q.push_back(v);
    cyc_q.push_back(c);
    sel_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [23:0] c);
    ctrl = c;
    tick();
    ctrl = '0;
  endtask

  // Brings a constant into DR through a memory read.
  task automatic load_dr(input logic [W-1:0] v);
    ctrl = RD;
    tick();
    ctrl = '0;
    mem_rdata = v;
    tick();
    mem_rdata = '0;
  endtask

  // Copies a register into DR so it becomes visible on mem_wdata.
  task automatic peek(input logic [23:0] sel, input logic [W-1:0] v, input string nm);
    push_exp(cyc + 1, S_WDATA, v, nm);
    step(sel | LD_DR);
  endtask

  initial begin
    // reset, with mem_rd following ctrl while reset is held
    repeat (2) tick();
    ctrl = RD;
    push_exp(cyc, S_RD, 16'd1, "rd_follows_ctrl_in_reset");
    tick();
    ctrl = '0;
    reset = 1'b0;
    push_exp(cyc, S_IR, 16'h0000, "reset_ir");
    push_exp(cyc, S_Z, 16'd0, "reset_z");
    push_exp(cyc, S_BUSY, 16'd0, "reset_busy_rd");
    push_exp(cyc, S_ADDR, 16'h0000, "reset_ar");
    push_exp(cyc, S_WDATA, 16'h0000, "reset_dr");
    push_exp(cyc, S_RD, 16'd0, "reset_mem_rd");
    push_exp(cyc, S_WR, 16'd0, "reset_mem_wr");
    step(B_ZERO | LD_AC);
    push_exp(cyc, S_Z, 16'd0, "ld_ac_zero_z_unchanged");
    peek(B_AC, 16'h0000, "ld_ac_zero");

    // single read from 0x0010
    load_dr(16'h0010);
    step(B_DR | LD_AR);
    ctrl = RD;
    push_exp(cyc, S_RD, 16'd1, "read_strobe");
    push_exp(cyc, S_ADDR, 16'h0010, "read_addr");
    push_exp(cyc + 1, S_BUSY, 16'd1, "read_busy_n1");
    tick();
    ctrl = '0;
    mem_rdata = 16'h1234;
    tick();
    mem_rdata = '0;
    push_exp(cyc, S_WDATA, 16'h1234, "read_dr_n2");
    push_exp(cyc, S_BUSY, 16'd0, "read_busy_n2");
    // read data beats a DR load from the bus in the capture cycle
    ctrl = RD;
    tick();
    ctrl = B_AC | LD_DR;
    mem_rdata = 16'h1234;
    tick();
    ctrl = '0;
    mem_rdata = '0;
    push_exp(cyc, S_WDATA, 16'h1234, "read_beats_ld_dr");
    // back-to-back reads capture one word per cycle
    ctrl = RD;
    tick();
    push_exp(cyc, S_BUSY, 16'd1, "b2b_busy_1");
    mem_rdata = 16'h1111;
    tick();
    ctrl = '0;
    push_exp(cyc, S_BUSY, 16'd1, "b2b_busy_2");
    push_exp(cyc, S_WDATA, 16'h1111, "b2b_first");
    mem_rdata = 16'h2222;
    tick();
    mem_rdata = '0;
    push_exp(cyc, S_WDATA, 16'h2222, "b2b_second");
    push_exp(cyc, S_BUSY, 16'd0, "b2b_busy_done");

    // ALU and z flag
    load_dr(16'h0005);
    step(B_DR | LD_AC | LD_R1);
    step(B_R1 | OP_SUB);
    push_exp(cyc, S_Z, 16'd1, "sub_z");
    peek(B_AC, 16'h0000, "sub_ac");
    load_dr(16'h0100);
    step(B_DR | LD_AC);
    step(B_DR | OP_MUL);
    push_exp(cyc, S_Z, 16'd1, "mul_z");
    peek(B_AC, 16'h0000, "mul_ac");
    step(OP_INC);
    push_exp(cyc, S_Z, 16'd0, "inc_z");
    peek(B_AC, 16'h0001, "inc_ac");
    push_exp(cyc, S_Z, 16'd0, "z_holds_0");
    step(B_DR | OP_ADD);
    peek(B_AC, 16'h0002, "add_ac");
    step(B_R1 | OP_SUB);
    push_exp(cyc, S_Z, 16'd0, "sub_wrap_z");
    peek(B_AC, 16'hFFFD, "sub_wrap_ac");
    step(B_R1 | OP_ADD | LD_AC);
    peek(B_AC, 16'h0002, "alu_beats_ld_ac");
    step(OP_CLR);
    push_exp(cyc, S_Z, 16'd1, "clr_z");
    peek(B_AC, 16'h0000, "clr_ac");
    push_exp(cyc, S_Z, 16'd1, "z_holds_1");
    step(B_R1 | OP_PASS);
    push_exp(cyc, S_Z, 16'd0, "pass_z");
    peek(B_AC, 16'h0005, "pass_ac");

    // counters and AR priorities
    load_dr(16'hFFFF);
    step(B_DR | LD_RC);
    step(INC_RC);
    peek(B_RC, 16'h0000, "rc_wrap");
    load_dr(16'h0007);
    step(B_DR | LD_R3);
    step(INC_CC);
    step(B_R3 | CLR_CC | INC_CC | LD_CC);
    peek(B_CC, 16'h0000, "cc_clr_wins");
    step(B_R3 | LD_CC | INC_CC);
    peek(B_CC, 16'h0007, "cc_ld_beats_inc");
    step(INC_CC);
    peek(B_CC, 16'h0008, "cc_inc");
    step(B_R3 | LD_RC);
    step(B_R3 | CLR_RC | LD_RC | INC_RC);
    peek(B_RC, 16'h0000, "rc_clr_wins");
    step(B_R3 | LD_RC | INC_RC);
    peek(B_RC, 16'h0007, "rc_ld_beats_inc");
    push_exp(cyc + 1, S_ADDR, 16'h0007, "ar_ld_beats_inc");
    step(B_R3 | LD_AR | INC_AR);
    push_exp(cyc + 1, S_ADDR, 16'h0008, "ar_inc");
    step(INC_AR);
    peek(B_AR, 16'h0008, "ar_on_bus");

    // writes, and write winning over a simultaneous read
    load_dr(16'h0020);
    step(B_DR | LD_AR);
    load_dr(16'hBEEF);
    ctrl = WR;
    push_exp(cyc, S_WR, 16'd1, "wr_strobe");
    push_exp(cyc, S_ADDR, 16'h0020, "wr_addr");
    push_exp(cyc, S_WDATA, 16'hBEEF, "wr_data");
    push_exp(cyc, S_RD, 16'd0, "wr_no_rd");
    tick();
    ctrl = WR | RD;
    push_exp(cyc, S_RD, 16'd0, "wr_rd_suppressed");
    push_exp(cyc, S_WR, 16'd1, "wr_rd_wr");
    push_exp(cyc + 1, S_BUSY, 16'd0, "wr_rd_no_busy");
    tick();
    ctrl = '0;
    push_exp(cyc, S_WDATA, 16'hBEEF, "wr_rd_dr_kept");
    tick();

    // IR path and the remaining bus sources
    load_dr(16'h00A5);
    push_exp(cyc + 1, S_IR, 16'h00A5, "ir_load");
    step(B_DR | LD_IR);
    step(B_IR | LD_R2);
    peek(B_R2, 16'h00A5, "ir_to_r2");
    step(B_R2 | LD_TR);
    peek(B_TR, 16'h00A5, "tr_load");
    peek(B_IR, 16'h00A5, "ir_on_bus");
    peek(B_11, 16'h0000, "bus_sel_11_zero");
    load_dr(16'h00FF);
    peek(B_R1, 16'h0005, "r1_on_bus");

    // reset during a pending read
    load_dr(16'h5555);
    ctrl = RD;
    tick();
    ctrl = '0;
    push_exp(cyc, S_BUSY, 16'd1, "pending_busy");
    mem_rdata = 16'h9999;
    reset = 1'b1;
    push_exp(cyc + 1, S_WDATA, 16'h0000, "reset_mid_read_dr");
    push_exp(cyc + 1, S_BUSY, 16'd0, "reset_mid_read_busy");
    push_exp(cyc + 1, S_IR, 16'h0000, "reset_mid_read_ir");
    push_exp(cyc + 1, S_Z, 16'd0, "reset_mid_read_z");
    tick();
    reset = 1'b0;
    mem_rdata = '0;
    repeat (3) tick();

    while (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: never checked (due cycle %0d)", name_q[0], cyc_q[0]);
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
      void'(sel_q.pop_front());
      void'(name_q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
